// File: rtl/dm_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_ctrl_if
// Description : Bundle between a load/store requester, the dm_access_ctrl
//               sequencer and the data memory.
//               Request side : req, op_st, base, offset, st_data -> ctrl
//                              busy, done, ld_data               <- ctrl
//               Memory side  : dm_read_addr, dm_write_addr,
//                              dm_write_data, dm_we              <- ctrl
//                              dm_read_data                      -> ctrl
//               modport slave  : the sequencer's view
//               modport master : the environment's view (requester + memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_access_ctrl_if;
    logic        req;
    logic        op_st;
    logic [15:0] base;
    logic [15:0] offset;
    logic [31:0] st_data;
    logic        busy;
    logic        done;
    logic [31:0] ld_data;
    logic [15:0] dm_read_addr;
    logic [15:0] dm_write_addr;
    logic [31:0] dm_write_data;
    logic        dm_we;
    logic [31:0] dm_read_data;

    modport slave (
        input  req, op_st, base, offset, st_data, dm_read_data,
        output busy, done, ld_data, dm_read_addr, dm_write_addr,
               dm_write_data, dm_we
    );

    modport master (
        output req, op_st, base, offset, st_data, dm_read_data,
        input  busy, done, ld_data, dm_read_addr, dm_write_addr,
               dm_write_data, dm_we
    );
endinterface
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_ctrl
// Description : Load/store sequencer between the SISC control/datapath and
//               data memory. One request at a time; effective address is
//               (base + offset) mod 2^16.
//               Load  : latch read address, wait RD_LAT edges, capture word.
//               Store : latch address/data, one setup cycle, dm_we high for
//                       WE_W cycles; memory commits on the dm_we falling edge.
// Ports       : clk   - system clock, rising edge
//               rst_f - asynchronous active-low reset
//               bus   - dm_access_ctrl_if.slave (request + memory signals)
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int RD_LAT = 1,   // 1..7
    parameter int WE_W   = 1    // 1..7
) (
    input  wire logic             clk,
    input  wire logic             rst_f,
    dm_access_ctrl_if.slave       bus
);

    localparam logic [2:0] C_IDLE     = 3'd0;
    localparam logic [2:0] C_RD_WAIT  = 3'd1;
    localparam logic [2:0] C_WR_SETUP = 3'd2;
    localparam logic [2:0] C_WR_PULSE = 3'd3;
    localparam logic [2:0] C_FINISH   = 3'd4;

    localparam logic [2:0] C_RD_LAT = 3'(RD_LAT);
    localparam logic [2:0] C_WE_W   = 3'(WE_W);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [2:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_ld_data;
    logic [15:0] r_rd_addr;
    logic [15:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [15:0] w_ea;
    logic        w_accept_ld;
    logic        w_accept_st;
    logic        w_last;

    // 16-bit sum: carry out is dropped by the width of w_ea.
    assign w_ea        = bus.base + bus.offset;
    assign w_accept_ld = (r_state == C_IDLE) &&  bus.req && !bus.op_st;
    assign w_accept_st = (r_state == C_IDLE) &&  bus.req &&  bus.op_st;
    // Counter value 1 before the edge means it reaches 0 on this edge.
    assign w_last      = (r_cnt == 3'd1);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (bus.req) begin
                    w_next = bus.op_st ? C_WR_SETUP : C_RD_WAIT;
                end
            end
            C_RD_WAIT: begin
                if (w_last) begin
                    w_next = C_FINISH;
                end
            end
            C_WR_SETUP: begin
                w_next = C_WR_PULSE;
            end
            C_WR_PULSE: begin
                if (w_last) begin
                    w_next = C_FINISH;
                end
            end
            C_FINISH: begin
                w_next = C_IDLE;
            end
            default: begin
                w_next = C_IDLE;
            end
        endcase
    end

    // ------------------------------------------------- counter / datapath
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_cnt     <= 3'd0;
            r_we      <= 1'b0;
            r_ld_data <= 32'd0;
            r_rd_addr <= 16'd0;
        end else begin
            // dm_we is a dedicated flop so the memory never sees a decode
            // glitch; the only way into WR_PULSE is from WR_SETUP.
            r_we <= (w_next == C_WR_PULSE);

            case (r_state)
                C_IDLE: begin
                    if (w_accept_ld) begin
                        r_cnt     <= C_RD_LAT;
                        r_rd_addr <= w_ea;
                    end
                end
                C_RD_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (w_last) begin
                        r_ld_data <= bus.dm_read_data;
                    end
                end
                C_WR_SETUP: begin
                    r_cnt <= C_WE_W;
                end
                C_WR_PULSE: begin
                    r_cnt <= r_cnt - 3'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Write address/data are deliberately unreset: a reset during WR_PULSE
    // drops dm_we and the memory must commit the coherent latched values.
    always_ff @(posedge clk) begin
        if (w_accept_st) begin
            r_wr_addr <= w_ea;
            r_wr_data <= bus.st_data;
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.busy          = (r_state != C_IDLE);
        bus.done          = (r_state == C_FINISH);
        bus.dm_we         = r_we;
        bus.ld_data       = r_ld_data;
        bus.dm_read_addr  = r_rd_addr;
        bus.dm_write_addr = r_wr_addr;
        bus.dm_write_data = r_wr_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_ctrl
// Description : Self-checking bench for dm_access_ctrl with RD_LAT=3, WE_W=2.
//               Contains a 64K-word data memory (commit on dm_we fall) and a
//               transaction-level reference memory used for expected loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

    localparam int P_RD_LAT = 3;
    localparam int P_WE_W   = 2;

    logic clk;
    logic rst_f;
    dm_access_ctrl_if bus ();

    dm_access_ctrl #(
        .RD_LAT (P_RD_LAT),
        .WE_W   (P_WE_W)
    ) u_dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------- data memory
    logic [31:0] mem [0:65535];
    logic        mem_armed;

    always @(negedge bus.dm_we) begin
        if (mem_armed) begin
            mem[bus.dm_write_addr] <= bus.dm_write_data;
        end
    end

    assign bus.dm_read_data = mem[bus.dm_read_addr];

    // -------------------------------------------------- reference model
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return {a ^ 16'hA5A5, a};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE and check latency, pulse width, data.
    task automatic run_op(input logic st, input logic [15:0] b,
                          input logic [15:0] o, input logic [31:0] d);
        logic [15:0] ea;
        int          n;
        int          we_cyc;
        ea = 16'((32'(b) + 32'(o)) % 65536);
        n = 0;
        while (bus.busy && n < 30) begin
            @(posedge clk); #1; n++;
        end
        check_val("idle_before_req", 32'(bus.busy), 32'd0);
        bus.req = 1'b1; bus.op_st = st; bus.base = b; bus.offset = o;
        bus.st_data = d;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check_val("busy_after_accept", 32'(bus.busy), 32'd1);
        n = 0; we_cyc = 0;
        while (!bus.done && n < 30) begin
            if (bus.dm_we) we_cyc++;
            @(posedge clk); #1; n++;
        end
        if (st) begin
            check_val("st_done_lat", 32'(n), 32'(1 + P_WE_W));
            check_val("st_we_width", 32'(we_cyc), 32'(P_WE_W));
            check_val("st_we_low_at_done", 32'(bus.dm_we), 32'd0);
            check_val("st_addr", 32'(bus.dm_write_addr), 32'(ea));
            check_val("st_data", bus.dm_write_data, d);
            ref_mem[int'(ea)] = d;
        end else begin
            check_val("ld_done_lat", 32'(n), 32'(P_RD_LAT));
            check_val("ld_addr", 32'(bus.dm_read_addr), 32'(ea));
            check_val("ld_data", bus.ld_data, exp_rd(ea));
        end
        @(posedge clk); #1;
        check_val("done_one_cycle", 32'(bus.done), 32'd0);
        check_val("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic        st;
        logic [15:0] ea;
        logic [31:0] val;
    } op_t;

    initial begin
        op_t         q[$];
        op_t         t;
        int          acc, dn, exp_acc, c, n, we_n;
        logic [15:0] tgt, b;

        mem_armed = 1'b0;
        rst_f = 1'b0;
        bus.req = 1'b0; bus.op_st = 1'b0; bus.base = '0; bus.offset = '0;
        bus.st_data = '0;
        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        #3;
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_we", 32'(bus.dm_we), 32'd0);
        check_val("rst_ld_data", bus.ld_data, 32'd0);
        check_val("rst_rd_addr", 32'(bus.dm_read_addr), 32'd0);
        #20;
        mem_armed = 1'b1;
        rst_f = 1'b1;
        @(posedge clk); #1;

        // Store then load through the same effective address.
        run_op(1'b1, 16'h0010, 16'h0004, 32'hDEADBEEF);
        run_op(1'b0, 16'h0014, 16'h0000, 32'h0);
        check_val("st_ld_roundtrip", bus.ld_data, 32'hDEADBEEF);

        // Address wrap on both paths.
        run_op(1'b0, 16'hFFFF, 16'h0002, 32'h0);
        check_val("wrap_rd_addr", 32'(bus.dm_read_addr), 32'h0001);
        run_op(1'b1, 16'h0003, 16'hFFFD, 32'hCAFE0000);
        check_val("wrap_wr_addr", 32'(bus.dm_write_addr), 32'h0000);
        run_op(1'b0, 16'h0000, 16'hFFFF, 32'h0);
        check_val("wrap_rd_ffff", 32'(bus.dm_read_addr), 32'hFFFF);
        run_op(1'b0, 16'hFFFF, 16'h0001, 32'h0);

        // Randomised load/store mix over a small address window.
        for (int i = 0; i < 24; i++) begin
            tgt = 16'($urandom_range(0, 31));
            b   = 16'($urandom);
            run_op(1'($urandom_range(0, 1)), b, tgt - b, $urandom);
        end

        // req held high with op_st alternating every cycle. Occupancy of
        // each op: load = RD_LAT + 2 cycles, store = WE_W + 3 cycles.
        exp_acc = 0; c = 0;
        while (c < 60) begin
            exp_acc++;
            c += (c % 2 == 1) ? (P_WE_W + 3) : (P_RD_LAT + 2);
        end
        acc = 0; dn = 0;
        for (int cy = 0; cy < 60; cy++) begin
            tgt = 16'($urandom_range(0, 31));
            b   = 16'($urandom);
            bus.req = 1'b1; bus.op_st = 1'(cy % 2); bus.base = b;
            bus.offset = tgt - b; bus.st_data = $urandom;
            if (bus.done) begin
                dn++;
                if (q.size() > 0) begin
                    t = q.pop_front();
                    if (!t.st) check_val("hold_ld_data", bus.ld_data, t.val);
                end
            end
            if (!bus.busy) begin
                acc++;
                t.st = bus.op_st; t.ea = tgt;
                if (bus.op_st) begin
                    t.val = bus.st_data;
                    ref_mem[int'(tgt)] = bus.st_data;
                end else begin
                    t.val = exp_rd(tgt);
                end
                q.push_back(t);
            end
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
        for (int cy = 0; cy < 12; cy++) begin
            if (bus.done) begin
                dn++;
                if (q.size() > 0) begin
                    t = q.pop_front();
                    if (!t.st) check_val("hold_ld_data", bus.ld_data, t.val);
                end
            end
            @(posedge clk); #1;
        end
        check_val("hold_accept_count", 32'(acc), 32'(exp_acc));
        check_val("hold_done_count", 32'(dn), 32'(acc));

        // Reset in the middle of the write-enable pulse.
        bus.req = 1'b1; bus.op_st = 1'b1; bus.base = 16'h0018;
        bus.offset = 16'h0008; bus.st_data = 32'h12345678;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        check_val("mid_st_we_high", 32'(bus.dm_we), 32'd1);
        #2 rst_f = 1'b0;
        #1;
        check_val("mid_st_rst_we", 32'(bus.dm_we), 32'd0);
        check_val("mid_st_rst_busy", 32'(bus.busy), 32'd0);
        check_val("mid_st_rst_done", 32'(bus.done), 32'd0);
        ref_mem[32'h20] = 32'h12345678;
        @(posedge clk); #3 rst_f = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 16'h0010, 16'h0010, 32'h0);
        check_val("mid_st_commit", bus.ld_data, 32'h12345678);

        // Reset while waiting on a load.
        bus.req = 1'b1; bus.op_st = 1'b0; bus.base = 16'h0030;
        bus.offset = 16'h0001;
        @(posedge clk); #1;
        bus.req = 1'b0;
        #2 rst_f = 1'b0;
        #1;
        check_val("mid_ld_rst_ld_data", bus.ld_data, 32'd0);
        check_val("mid_ld_rst_rd_addr", 32'(bus.dm_read_addr), 32'd0);
        check_val("mid_ld_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #3 rst_f = 1'b1;
        n = 0; we_n = 0;
        for (int cy = 0; cy < 8; cy++) begin
            @(posedge clk); #1;
            if (bus.done) n++;
            if (bus.dm_we) we_n++;
        end
        check_val("mid_ld_no_done", 32'(n), 32'd0);
        check_val("mid_ld_no_we", 32'(we_n), 32'd0);
        run_op(1'b0, 16'h0030, 16'h0001, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
